// File: rtl/hazard_control_unit.sv
// RAW scoreboard plus branch-flush sequencer beside decode; outputs are combinational, zero-cycle stall.
// Optional stall performance counter is built only when HAZARD_PERF_EN is defined.
module hazard_control_unit #(
  parameter int NUM_REGS     = 16,
  parameter int WB_LATENCY   = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        dec_valid,
  input  logic [$clog2(NUM_REGS)-1:0] dec_address_a,
  input  logic [$clog2(NUM_REGS)-1:0] dec_address_b,
  input  logic                        dec_uses_a,
  input  logic                        dec_uses_b,
  input  logic [$clog2(NUM_REGS)-1:0] dec_destiny,
  input  logic                        dec_writes,
  input  logic                        branch_taken,
  output logic                        pc_write,
  output logic                        decode_enable,
  output logic                        flush_decode,
  output logic                        ex_bubble,
  output logic                        issue,
  output logic [CNT_W-1:0]            stall_count
);

  localparam int AW   = $clog2(NUM_REGS);
  localparam int SB_W = $clog2(WB_LATENCY + 1);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [SB_W-1:0] SB_LOAD = SB_W'(WB_LATENCY);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [FC_W-1:0] r_fcnt;
  logic [FC_W-1:0] w_fcnt_nxt;
  logic [SB_W-1:0] r_sb     [NUM_REGS];
  logic [SB_W-1:0] w_sb_nxt [NUM_REGS];

  logic w_hazard;
  logic w_flush;
  logic w_stall;
  logic w_issue;

  assign w_hazard = dec_valid &
                    ((dec_uses_a & (r_sb[dec_address_a] != '0)) |
                     (dec_uses_b & (r_sb[dec_address_b] != '0)));

  always_comb begin
    w_state_nxt   = r_state;
    w_fcnt_nxt    = r_fcnt;
    w_flush       = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_flush = branch_taken;
        if (branch_taken && (FLUSH_CYCLES > 1)) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FC_LOAD;
        end
      end
      ST_FLUSH: begin
        // branch_taken is deliberately not looked at here
        w_flush    = 1'b1;
        w_fcnt_nxt = r_fcnt - 1'b1;
        if (r_fcnt == FC_W'(1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
    w_stall       = w_hazard & ~w_flush;
    w_issue       = dec_valid & ~w_hazard & ~w_flush;
    pc_write      = ~w_stall;
    decode_enable = ~w_stall;
    flush_decode  = w_flush;
    ex_bubble     = ~w_issue;
    issue         = w_issue;
  end

  // A fresh load on the destination overrides that register's countdown (WAW restart).
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_sb_nxt[i] = r_sb[i];
      if (w_issue && dec_writes && (dec_destiny == AW'(i))) begin
        w_sb_nxt[i] = SB_LOAD;
      end else if (r_sb[i] != '0) begin
        w_sb_nxt[i] = r_sb[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_fcnt  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_sb[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_sb[i] <= w_sb_nxt[i];
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed vector bench for hazard_control_unit: one table row per clock cycle, outputs sampled at negedge.
module tb_hazard_control_unit;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             dec_valid;
  logic [3:0]       dec_address_a;
  logic [3:0]       dec_address_b;
  logic             dec_uses_a;
  logic             dec_uses_b;
  logic [3:0]       dec_destiny;
  logic             dec_writes;
  logic             branch_taken;
  logic             pc_write;
  logic             decode_enable;
  logic             flush_decode;
  logic             ex_bubble;
  logic             issue;
  logic [CNT_W-1:0] stall_count;

  int n_vec  = 0;
  int n_miss = 0;

  hazard_control_unit #(
    .NUM_REGS(16), .WB_LATENCY(3), .FLUSH_CYCLES(2), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .dec_valid(dec_valid),
    .dec_address_a(dec_address_a), .dec_address_b(dec_address_b),
    .dec_uses_a(dec_uses_a), .dec_uses_b(dec_uses_b),
    .dec_destiny(dec_destiny), .dec_writes(dec_writes),
    .branch_taken(branch_taken), .pc_write(pc_write),
    .decode_enable(decode_enable), .flush_decode(flush_decode),
    .ex_bubble(ex_bubble), .issue(issue), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, vld;
    logic [3:0] a;
    logic       ua;
    logic [3:0] b;
    logic       ub;
    logic [3:0] d;
    logic       wr, br;
    logic       pcw, den, fl, bub, iss;
    int         cnt;
  } vec_t;

  function automatic vec_t v(
    input logic rst, input logic vld, input logic [3:0] a, input logic ua,
    input logic [3:0] b, input logic ub, input logic [3:0] d, input logic wr,
    input logic br, input logic pcw, input logic den, input logic fl,
    input logic bub, input logic iss, input int cnt);
    vec_t r;
    r.rst = rst; r.vld = vld; r.a = a; r.ua = ua; r.b = b; r.ub = ub;
    r.d = d; r.wr = wr; r.br = br; r.pcw = pcw; r.den = den; r.fl = fl;
    r.bub = bub; r.iss = iss; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    int ecnt;
    @(posedge clock);
    #1;
    reset = t.rst; dec_valid = t.vld; dec_address_a = t.a; dec_uses_a = t.ua;
    dec_address_b = t.b; dec_uses_b = t.ub; dec_destiny = t.d;
    dec_writes = t.wr; branch_taken = t.br;
    @(negedge clock);
`ifdef HAZARD_PERF_EN
    ecnt = t.cnt;
`else
    ecnt = 0;
`endif
    n_vec++;
    chk("pc_write",      idx, 16'(pc_write),      16'(t.pcw));
    chk("decode_enable", idx, 16'(decode_enable), 16'(t.den));
    chk("flush_decode",  idx, 16'(flush_decode),  16'(t.fl));
    chk("ex_bubble",     idx, 16'(ex_bubble),     16'(t.bub));
    chk("issue",         idx, 16'(issue),         16'(t.iss));
    chk("stall_count",   idx, 16'(stall_count),   16'(ecnt));
  endtask

  vec_t tbl[$];

  initial begin
    // rst vld a ua b ub d wr br | pcw den fl bub iss cnt
    tbl.push_back(v(1,0,0,0,0,0,0,0,0, 1,1,0,1,0,0));   // reset state
    tbl.push_back(v(0,1,1,1,0,1,3,1,0, 1,1,0,0,1,0));   // r3 <- r1,r0
    tbl.push_back(v(0,1,2,1,4,1,5,1,0, 1,1,0,0,1,0));   // r5 <- r2,r4
    tbl.push_back(v(0,1,3,1,0,0,6,0,0, 0,0,0,1,0,0));   // sb3=2
    tbl.push_back(v(0,1,3,1,0,0,6,0,0, 0,0,0,1,0,1));   // sb3=1
    tbl.push_back(v(0,1,3,1,0,0,6,0,0, 1,1,0,0,1,2));   // sb3=0 readable
    tbl.push_back(v(0,1,0,0,0,0,3,1,0, 1,1,0,0,1,2));   // RAW: write r3
    tbl.push_back(v(0,1,3,1,0,0,8,1,0, 0,0,0,1,0,2));
    tbl.push_back(v(0,1,3,1,0,0,8,1,0, 0,0,0,1,0,3));
    tbl.push_back(v(0,1,3,1,0,0,8,1,0, 0,0,0,1,0,4));
    tbl.push_back(v(0,1,3,1,0,0,8,1,0, 1,1,0,0,1,5));   // issues N+4
    tbl.push_back(v(0,1,8,0,8,0,0,0,0, 1,1,0,0,1,5));   // r8 busy but unused
    tbl.push_back(v(0,1,0,0,8,1,0,0,0, 0,0,0,1,0,5));   // r8 read via B
    tbl.push_back(v(0,0,0,0,8,1,0,0,0, 1,1,0,1,0,6));   // idle: no stall
    tbl.push_back(v(0,1,0,0,8,1,0,0,0, 1,1,0,0,1,6));
    tbl.push_back(v(0,1,0,0,0,0,3,1,0, 1,1,0,0,1,6));   // WAW: write r3
    tbl.push_back(v(0,1,0,0,0,0,3,1,0, 1,1,0,0,1,6));   // write r3 again
    tbl.push_back(v(0,1,3,1,0,0,0,0,0, 0,0,0,1,0,6));
    tbl.push_back(v(0,1,3,1,0,0,0,0,0, 0,0,0,1,0,7));
    tbl.push_back(v(0,1,3,1,0,0,0,0,0, 0,0,0,1,0,8));
    tbl.push_back(v(0,1,3,1,0,0,0,0,0, 1,1,0,0,1,9));
    tbl.push_back(v(0,1,0,0,0,0,7,1,0, 1,1,0,0,1,9));   // write r7
    tbl.push_back(v(0,1,0,0,7,1,9,1,0, 0,0,0,1,0,9));   // stall on r7
    tbl.push_back(v(0,1,0,0,7,1,9,1,1, 1,1,1,1,0,10));  // branch kills stalled op
    tbl.push_back(v(0,1,0,0,7,1,9,1,1, 1,1,1,1,0,10));  // second branch ignored
    tbl.push_back(v(0,1,9,1,7,1,0,0,0, 1,1,0,0,1,10));  // r9 never loaded
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,1,0,1,0,10));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1, 1,1,1,1,0,10));  // single branch pulse
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,1,1,1,0,10));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,1,0,1,0,10));
    tbl.push_back(v(0,1,0,0,0,0,4,1,1, 1,1,1,1,0,10));  // flush beats issue
    tbl.push_back(v(0,1,4,1,0,0,0,0,0, 1,1,1,1,0,10));
    tbl.push_back(v(0,1,4,1,0,0,0,0,0, 1,1,0,0,1,10));  // r4 never loaded

    reset = 1'b1; dec_valid = 1'b0; dec_address_a = '0; dec_address_b = '0;
    dec_uses_a = 1'b0; dec_uses_b = 1'b0; dec_destiny = '0;
    dec_writes = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // reset in the middle of FLUSH with sb[7]=2
    apply(v(0,1,0,0,0,0,7,1,0, 1,1,0,0,1,10), 100);
    apply(v(0,0,0,0,0,0,0,0,1, 1,1,1,1,0,10), 101);
    apply(v(1,0,0,0,0,0,0,0,0, 1,1,1,1,0,10), 102);
    apply(v(0,1,7,1,0,0,0,0,0, 1,1,0,0,1,0),  103);
    // reset wins over a same-cycle issue and a same-cycle branch
    apply(v(1,1,0,0,0,0,5,1,0, 1,1,0,0,1,0),  104);
    apply(v(0,1,5,1,0,0,0,0,0, 1,1,0,0,1,0),  105);
    apply(v(1,0,0,0,0,0,0,0,1, 1,1,1,1,0,0),  106);
    apply(v(0,0,0,0,0,0,0,0,0, 1,1,0,1,0,0),  107);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and flush controller for the SIMD AES core. It sits beside the decode stage and tracks in-flight register writes in a per-register scoreboard. When a decoded instruction has a read-after-write conflict, it stalls fetch/decode and injects a bubble into execute. When execute resolves a taken branch, it sequences a multi-cycle flush of the younger stages.

## Interface
Parameters:
- NUM_REGS, 16, register file entries (4-bit address)
- WB_LATENCY, 3, cycles from issue out of decode until the destination value is readable by decode
- FLUSH_CYCLES, 2, cycles flush_decode stays asserted per taken branch (≥1)
- CNT_W, 16, width of the stall performance counter

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- dec_valid  in  1  decode holds a real instruction
- dec_address_a  in  4  source register A ("rs")
- dec_address_b  in  4  source register B ("rt")
- dec_uses_a  in  1  instruction reads A
- dec_uses_b  in  1  instruction reads B
- dec_destiny  in  4  destination register
- dec_writes  in  1  instruction writes dec_destiny
- branch_taken  in  1  execute resolved a taken branch this cycle
- pc_write  out  1  fetch may update PC
- decode_enable  out  1  IF/ID register may load
- flush_decode  out  1  clear IF/ID to a NOP
- ex_bubble  out  1  load a NOP into ID/EX instead of decode output
- issue  out  1  decode instruction advances to execute this cycle
- stall_count  out  CNT_W  RAW stall cycles since reset (HAZARD_PERF_EN only)

## Operation
- Scoreboard: one counter per register, width clog2(WB_LATENCY+1). All counters reset to 0.
- Hazard, combinational:
  - hazard = dec_valid & ((dec_uses_a & sb[dec_address_a]≠0) | (dec_uses_b & sb[dec_address_b]≠0)).
  - All 16 registers are tracked. No register is hardwired.
- flush = branch_taken (in RUN) | state==FLUSH.
- issue = dec_valid & ~hazard & ~flush.
- On issue with dec_writes: sb[dec_destiny] ← WB_LATENCY.
- Every other nonzero counter decrements by 1 each cycle.
- Same-cycle load and decrement on one register: the load wins.
- WAW is covered by the reload. A younger write restarts the counter.
- Stall (hazard & ~flush): pc_write=0, decode_enable=0, ex_bubble=1. The scoreboard still counts down.
- FSM states:
  - RUN → FLUSH on branch_taken when FLUSH_CYCLES>1. The flush counter loads FLUSH_CYCLES-1.
  - FLUSH → RUN when the counter reaches 1 and decrements.
  - branch_taken is ignored while in FLUSH.
- Flush output: flush_decode=1, ex_bubble=1, pc_write=1 (the branch target loads in cycle N), decode_enable=1, issue=0.
- Flush beats stall. The killed instruction never sets the scoreboard. Older counters keep running.
- Idle (dec_valid=0, no flush): pc_write=1, decode_enable=1, ex_bubble=1, issue=0.

## Timing
- Reset values:
  - Scoreboard all 0; state RUN.
  - pc_write=1, decode_enable=1, flush_decode=0, issue=0, ex_bubble=1 (dec_valid assumed 0), stall_count=0.
- Reset has priority over branch_taken and issue in the same cycle. Reset mid-FLUSH returns to RUN next cycle.
- Outputs are combinational from current inputs and registered state. Zero-cycle stall decision.
- Dependency spacing:
  - A dependent instruction directly behind a writer stalls WB_LATENCY cycles, then issues in cycle N+WB_LATENCY+1 if the writer issued in cycle N.
  - A register whose counter reads 0 is readable in that cycle. The register file is write-before-read.
- Flush window: branch_taken in cycle N gives flush_decode=1 in cycles N..N+FLUSH_CYCLES-1.
- stall_count increments once per cycle with hazard & ~flush. It saturates at all-ones.

## Configuration
- HAZARD_PERF_EN defined: stall_count is implemented as above.
- Not defined: stall_count is tied to 0 and the counter flops are removed. All other behaviour is identical.

## Test plan
- Independent stream: ADD r3←r1,r0, then ADD r5←r2,r4, back to back → no stall; issue=1 both cycles; sb[3]=3 then 2.
- RAW: write r3 (cycle 0), then read r3 as A (cycle 1) → decode_enable=0, ex_bubble=1 in cycles 1–3; issue=1 in cycle 4. With HAZARD_PERF_EN, stall_count=3.
- WAW reload: write r3 in cycle 0 and again in cycle 1 → sb[3]=3 after cycle 1. A reader of r3 issues no earlier than cycle 5.
- Branch during stall:
  - Setup: a RAW stall is active and branch_taken=1 in cycle N.
  - flush_decode=1 and stall deasserted in cycles N and N+1 (FLUSH_CYCLES=2).
  - issue=0 in both cycles; the scoreboard is not loaded by the killed instruction.
- branch_taken asserted in cycles N and N+1 → the flush lasts only N..N+1. The second assertion is ignored.
- Reset in the middle of FLUSH with sb[7]=2 → next cycle: state RUN, sb[7]=0, flush_decode=0, stall_count=0.
